// File: rtl/rf_seq_pkg.sv
// Shared definitions for the register-file operation sequencer:
// opcode and state encodings, default widths and operand-usage helpers.
package rf_seq_pkg;

  localparam int DW_DEF = 16;
  localparam int AW_DEF = 5;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_AND  = 3'd3,
    OP_OR   = 3'd4,
    OP_XOR  = 3'd5,
    OP_MOVI = 3'd6,
    OP_READ = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_EX   = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  // Two-operand ALU ops read both ports; READ only needs port 1.
  function automatic logic reads_src1(input op_t op);
    return (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_READ});
  endfunction

  function automatic logic reads_src2(input op_t op);
    return (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR});
  endfunction

endpackage

// File: rtl/rf_op_sequencer_if.sv
// Bundle of the issue handshake, register-file ports and completion report.
// master: issue logic plus register file (the sequencer's environment).
// slave:  the sequencer itself.
interface rf_op_sequencer_if
  import rf_seq_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
);

  logic          op_valid;
  logic          op_ready;
  logic [2:0]    op_code;
  logic [AW-1:0] op_src1;
  logic [AW-1:0] op_src2;
  logic [AW-1:0] op_dst;
  logic [DW-1:0] op_imm;

  logic [AW-1:0] rf_rp1;
  logic [AW-1:0] rf_rp2;
  logic [AW-1:0] rf_wp;
  logic [DW-1:0] rf_wd;
  logic          rf_rd_en1;
  logic          rf_rd_en2;
  logic          rf_wr_en;
  logic [DW-1:0] rf_rd1;
  logic [DW-1:0] rf_rd2;

  logic          res_valid;
  logic [DW-1:0] res_data;
  logic          res_zero;
  logic          res_carry;
  logic [15:0]   op_count;

  modport master (
    output op_valid, op_code, op_src1, op_src2, op_dst, op_imm, rf_rd1, rf_rd2,
    input  op_ready, rf_rp1, rf_rp2, rf_wp, rf_wd, rf_rd_en1, rf_rd_en2, rf_wr_en,
    input  res_valid, res_data, res_zero, res_carry, op_count
  );

  modport slave (
    input  op_valid, op_code, op_src1, op_src2, op_dst, op_imm, rf_rd1, rf_rd2,
    output op_ready, rf_rp1, rf_rp2, rf_wp, rf_wd, rf_rd_en1, rf_rd_en2, rf_wr_en,
    output res_valid, res_data, res_zero, res_carry, op_count
  );

endinterface

// File: rtl/rf_seq_alu.sv
// Combinational ALU for the sequencer. A 17-bit add/sub provides the
// carry-out for ADD and the borrow (a < b) for SUB; other ops report carry 0.
module rf_seq_alu
  import rf_seq_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  op_t           op_code,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] imm,
  output logic [DW-1:0] result,
  output logic          zero,
  output logic          carry
);

  logic [DW:0] sum;
  logic [DW:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  // Select result and carry/borrow by opcode; NOP yields zero.
  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (op_code)
      OP_ADD:  begin result = sum[DW-1:0];  carry = sum[DW];  end
      OP_SUB:  begin result = diff[DW-1:0]; carry = diff[DW]; end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_MOVI: result = imm;
      OP_READ: result = a;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/rf_op_sequencer.sv
// Single-issue sequencer: walks one operation at a time through register
// read, execute and write-back against a registered-read register file.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_IDLE | op_ready high, waiting for op_valid
//   ST_RD   | read addresses/enables presented to the register file
//   ST_EX   | read data valid; ALU result and flags registered
//   ST_WB   | write-back pulse, res_valid pulse, count at end of cycle
module rf_op_sequencer
  import rf_seq_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int AW       = AW_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  rf_op_sequencer_if.slave  bus
);

  state_t        state;
  op_t           op_q;
  logic [AW-1:0] dst_q;
  logic [DW-1:0] imm_q;

  logic [DW-1:0] alu_result;
  logic          alu_zero;
  logic          alu_carry;
  logic          wr_ok;

  rf_seq_alu #(.DW(DW)) u_alu (
    .op_code (op_q),
    .a       (bus.rf_rd1),
    .b       (bus.rf_rd2),
    .imm     (imm_q),
    .result  (alu_result),
    .zero    (alu_zero),
    .carry   (alu_carry)
  );

  // NOP and READ never write; r0 is read-only when ZERO_REG is set.
  assign wr_ok = (op_q != OP_NOP) && (op_q != OP_READ) &&
                 !((ZERO_REG != 0) && (dst_q == '0));

  // Sequencer FSM with registered register-file and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      op_q          <= OP_NOP;
      dst_q         <= '0;
      imm_q         <= '0;
      bus.op_ready  <= 1'b1;
      bus.rf_rp1    <= '0;
      bus.rf_rp2    <= '0;
      bus.rf_wp     <= '0;
      bus.rf_wd     <= '0;
      bus.rf_rd_en1 <= 1'b0;
      bus.rf_rd_en2 <= 1'b0;
      bus.rf_wr_en  <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      bus.res_zero  <= 1'b0;
      bus.res_carry <= 1'b0;
      bus.op_count  <= '0;
    end else begin
      // Pulse outputs default low; everything else holds.
      bus.rf_rd_en1 <= 1'b0;
      bus.rf_rd_en2 <= 1'b0;
      bus.rf_wr_en  <= 1'b0;
      bus.res_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.op_valid) begin
            op_q          <= op_t'(bus.op_code);
            dst_q         <= bus.op_dst;
            imm_q         <= bus.op_imm;
            bus.rf_rp1    <= bus.op_src1;
            bus.rf_rp2    <= bus.op_src2;
            bus.rf_rd_en1 <= reads_src1(op_t'(bus.op_code));
            bus.rf_rd_en2 <= reads_src2(op_t'(bus.op_code));
            bus.op_ready  <= 1'b0;
            state         <= ST_RD;
          end
        end
        ST_RD: begin
          state <= ST_EX;
        end
        ST_EX: begin
          bus.rf_wp     <= dst_q;
          bus.rf_wd     <= alu_result;
          bus.rf_wr_en  <= wr_ok;
          bus.res_data  <= alu_result;
          bus.res_zero  <= alu_zero;
          bus.res_carry <= alu_carry;
          bus.res_valid <= 1'b1;
          state         <= ST_WB;
        end
        ST_WB: begin
          bus.op_count <= bus.op_count + 16'd1;
          bus.op_ready <= 1'b1;
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_op_sequencer.sv
// Directed bench for rf_op_sequencer with a behavioural 32x16 register file.
module tb_rf_op_sequencer;
  import rf_seq_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  rf_op_sequencer_if #(.DW(16), .AW(5)) bus_if ();

  rf_op_sequencer #(.DW(16), .AW(5), .ZERO_REG(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // Register file model: registered reads, synchronous write.
  logic [15:0] mem [32] = '{default: 16'h0000};

  always @(posedge clk) begin
    if (bus_if.rf_rd_en1) bus_if.rf_rd1 <= mem[bus_if.rf_rp1];
    if (bus_if.rf_rd_en2) bus_if.rf_rd2 <= mem[bus_if.rf_rp2];
    if (bus_if.rf_wr_en)  mem[bus_if.rf_wp] <= bus_if.rf_wd;
  end

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0]  code;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic [4:0]  d;
    logic [15:0] imm;
    logic [15:0] data;
    logic        z;
    logic        c;
    logic        we;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  // Captured per-operation observations.
  logic [15:0] r_data;
  logic        r_zero, r_carry, r_en1, r_en2, r_rdy_rd;
  logic [4:0]  r_wp, r_rp1, r_rp2;
  logic [15:0] r_wd;
  int          r_we_cnt, r_lat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] code, input logic [4:0] s1, input logic [4:0] s2,
                              input logic [4:0] d, input logic [15:0] imm, input logic [15:0] data,
                              input logic z, input logic c, input logic we);
    vec_t v;
    v.code = code; v.s1 = s1; v.s2 = s2; v.d = d; v.imm = imm;
    v.data = data; v.z = z; v.c = c; v.we = we;
    return v;
  endfunction

  function automatic logic exp_en1(input logic [2:0] code);
    return (code >= 3'd1 && code <= 3'd5) || (code == 3'd7);
  endfunction

  function automatic logic exp_en2(input logic [2:0] code);
    return (code >= 3'd1 && code <= 3'd5);
  endfunction

  // Issue one op from an IDLE negedge; returns at the IDLE negedge after WB.
  task automatic do_op(input logic [2:0] code, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [4:0] d, input logic [15:0] imm);
    int n;
    bus_if.op_valid = 1'b1;
    bus_if.op_code  = code;
    bus_if.op_src1  = s1;
    bus_if.op_src2  = s2;
    bus_if.op_dst   = d;
    bus_if.op_imm   = imm;
    n = 0;
    while (!bus_if.op_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    bus_if.op_valid = 1'b0;
    r_en1    = bus_if.rf_rd_en1;
    r_en2    = bus_if.rf_rd_en2;
    r_rp1    = bus_if.rf_rp1;
    r_rp2    = bus_if.rf_rp2;
    r_rdy_rd = bus_if.op_ready;
    r_we_cnt = bus_if.rf_wr_en ? 1 : 0;
    r_lat    = 1;
    while (!bus_if.res_valid && r_lat < 10) begin
      @(negedge clk);
      r_lat++;
      if (bus_if.rf_wr_en) r_we_cnt++;
    end
    r_data  = bus_if.res_data;
    r_zero  = bus_if.res_zero;
    r_carry = bus_if.res_carry;
    r_wp    = bus_if.rf_wp;
    r_wd    = bus_if.rf_wd;
    @(negedge clk);
    if (bus_if.rf_wr_en) r_we_cnt++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [12:0] exp_rdy_mask;
    logic [12:0] exp_val_mask;
    int          wr_in_rst;

    vecs[0]  = mk(3'd6,  0, 0,  3, 16'h1234, 16'h1234, 0, 0, 1);
    vecs[1]  = mk(3'd6,  0, 0,  4, 16'h0FFF, 16'h0FFF, 0, 0, 1);
    vecs[2]  = mk(3'd1,  3, 4,  5, 16'h0000, 16'h2233, 0, 0, 1);
    vecs[3]  = mk(3'd7,  5, 0, 15, 16'h0000, 16'h2233, 0, 0, 0);
    vecs[4]  = mk(3'd6,  0, 0,  1, 16'hFFFF, 16'hFFFF, 0, 0, 1);
    vecs[5]  = mk(3'd6,  0, 0,  2, 16'h0001, 16'h0001, 0, 0, 1);
    vecs[6]  = mk(3'd1,  1, 2,  6, 16'h0000, 16'h0000, 1, 1, 1);
    vecs[7]  = mk(3'd2,  2, 1,  7, 16'h0000, 16'h0002, 0, 1, 1);
    vecs[8]  = mk(3'd6,  0, 0,  0, 16'hBEEF, 16'hBEEF, 0, 0, 0);
    vecs[9]  = mk(3'd7,  0, 0,  0, 16'h0000, 16'h0000, 1, 0, 0);
    vecs[10] = mk(3'd3,  3, 4,  8, 16'h0000, 16'h0234, 0, 0, 1);
    vecs[11] = mk(3'd4,  3, 4, 10, 16'h0000, 16'h1FFF, 0, 0, 1);
    vecs[12] = mk(3'd5,  3, 4, 11, 16'h0000, 16'h1DCB, 0, 0, 1);
    vecs[13] = mk(3'd0,  3, 4, 16, 16'h7777, 16'h0000, 1, 0, 0);
    vecs[14] = mk(3'd2,  3, 3, 12, 16'h0000, 16'h0000, 1, 0, 1);
    vecs[15] = mk(3'd7,  6, 0,  0, 16'h0000, 16'h0000, 1, 0, 0);
    vecs[16] = mk(3'd2,  3, 2, 13, 16'h0000, 16'h1233, 0, 0, 1);
    vecs[17] = mk(3'd7,  7, 0,  0, 16'h0000, 16'h0002, 0, 0, 0);

    rst             = 1'b1;
    bus_if.op_valid = 1'b0;
    bus_if.op_code  = 3'd0;
    bus_if.op_src1  = '0;
    bus_if.op_src2  = '0;
    bus_if.op_dst   = '0;
    bus_if.op_imm   = '0;

    #12;
    check("rst op_ready",  32'(bus_if.op_ready),  32'd1);
    check("rst rd_en1",    32'(bus_if.rf_rd_en1), 32'd0);
    check("rst wr_en",     32'(bus_if.rf_wr_en),  32'd0);
    check("rst res_valid", 32'(bus_if.res_valid), 32'd0);
    check("rst res_data",  32'(bus_if.res_data),  32'd0);
    check("rst op_count",  32'(bus_if.op_count),  32'd0);

    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven single operations.
    for (int i = 0; i < NV; i++) begin
      do_op(vecs[i].code, vecs[i].s1, vecs[i].s2, vecs[i].d, vecs[i].imm);
      check($sformatf("v%0d latency", i),  32'(r_lat),    32'd3);
      check($sformatf("v%0d ready_rd", i), 32'(r_rdy_rd), 32'd0);
      check($sformatf("v%0d rd_en1", i),   32'(r_en1),    32'(exp_en1(vecs[i].code)));
      check($sformatf("v%0d rd_en2", i),   32'(r_en2),    32'(exp_en2(vecs[i].code)));
      check($sformatf("v%0d rp1", i),      32'(r_rp1),    32'(vecs[i].s1));
      check($sformatf("v%0d rp2", i),      32'(r_rp2),    32'(vecs[i].s2));
      check($sformatf("v%0d data", i),     32'(r_data),   32'(vecs[i].data));
      check($sformatf("v%0d zero", i),     32'(r_zero),   32'(vecs[i].z));
      check($sformatf("v%0d carry", i),    32'(r_carry),  32'(vecs[i].c));
      check($sformatf("v%0d wr_cnt", i),   32'(r_we_cnt), 32'(vecs[i].we));
      if (vecs[i].we) begin
        check($sformatf("v%0d wp", i), 32'(r_wp), 32'(vecs[i].d));
        check($sformatf("v%0d wd", i), 32'(r_wd), 32'(vecs[i].data));
      end
      check($sformatf("v%0d count", i), 32'(bus_if.op_count), 32'(i + 1));
    end

    // Back-to-back: op_valid held high across three operations.
    exp_rdy_mask = 13'b1_0001_0001_0001;
    exp_val_mask = 13'b0_1000_1000_1000;
    bus_if.op_valid = 1'b1;
    bus_if.op_code  = 3'd6;
    bus_if.op_src1  = 5'd0;
    bus_if.op_src2  = 5'd0;
    bus_if.op_dst   = 5'd14;
    bus_if.op_imm   = 16'h00A5;
    for (int t = 0; t < 13; t++) begin
      check($sformatf("b2b ready c%0d", t), 32'(bus_if.op_ready),  32'(exp_rdy_mask[t]));
      check($sformatf("b2b valid c%0d", t), 32'(bus_if.res_valid), 32'(exp_val_mask[t]));
      if (t == 9) bus_if.op_valid = 1'b0;
      @(negedge clk);
    end
    check("b2b count", 32'(bus_if.op_count), 32'd21);
    check("b2b r14",   32'(mem[14]),         32'h00A5);

    // Reset during EX of ADD r9 must drop the write.
    do_op(3'd6, 0, 0, 9, 16'h5A5A);
    check("pre-rst count", 32'(bus_if.op_count), 32'd22);
    bus_if.op_valid = 1'b1;
    bus_if.op_code  = 3'd1;
    bus_if.op_src1  = 5'd3;
    bus_if.op_src2  = 5'd4;
    bus_if.op_dst   = 5'd9;
    @(negedge clk);
    bus_if.op_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid rst ready",  32'(bus_if.op_ready), 32'd1);
    check("mid rst rp1",    32'(bus_if.rf_rp1),   32'd0);
    check("mid rst wp",     32'(bus_if.rf_wp),    32'd0);
    check("mid rst wd",     32'(bus_if.rf_wd),    32'd0);
    check("mid rst data",   32'(bus_if.res_data), 32'd0);
    check("mid rst count",  32'(bus_if.op_count), 32'd0);
    check("mid rst wr_en",  32'(bus_if.rf_wr_en), 32'd0);
    wr_in_rst = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus_if.rf_wr_en) wr_in_rst++;
      if (k == 1) rst = 1'b0;
    end
    check("rst no write", 32'(wr_in_rst), 32'd0);
    do_op(3'd7, 9, 0, 0, 16'h0000);
    check("post-rst r9",    32'(r_data),          32'h5A5A);
    check("post-rst count", 32'(bus_if.op_count), 32'd1);

    // Counter wrap from 0xFFFF.
    force bus_if.op_count = 16'hFFFF;
    @(negedge clk);
    release bus_if.op_count;
    @(negedge clk);
    do_op(3'd0, 0, 0, 0, 16'h0000);
    check("wrap nop zero", 32'(r_zero),          32'd1);
    check("wrap count",    32'(bus_if.op_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
